// File: rtl/ibex_pkg.sv
// Shared ibex types: mult/div operator encoding plus the mult/div issue FSM state set.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ISS_IDLE,
    MD_ISS_BUSY,
    MD_ISS_DRAIN
  } md_issue_fsm_e;

  localparam int unsigned MD_MAX_CYCLES = 48;
  localparam int unsigned MD_OP_W       = 32;
  localparam int unsigned MD_IMD_W      = 34;

  // Request fields held stable for the whole mult/div operation.
  typedef struct packed {
    md_op_e              operator;
    logic [1:0]          signed_mode;
    logic                is_div;
    logic [MD_OP_W-1:0]  op_a;
    logic [MD_OP_W-1:0]  op_b;
  } md_req_t;

endpackage

// File: rtl/ibex_multdiv_imd_regs.sv
// Pair of write-enabled 34-bit intermediate-value registers owned on behalf of the mult/div unit.
module ibex_multdiv_imd_regs
  import ibex_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [MD_IMD_W-1:0] imd_val_d_i  [2],
  input  logic [1:0]          imd_val_we_i,
  output logic [MD_IMD_W-1:0] imd_val_q_o  [2]
);

  logic [MD_IMD_W-1:0] r_imd [2];

  // Each slot writes independently; contents persist across operations.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        r_imd[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i]) begin
          r_imd[i] <= imd_val_d_i[i];
        end
      end
    end
  end

  assign imd_val_q_o = r_imd;

endmodule

// File: rtl/ibex_multdiv_issue.sv
// ID/EX-side issue controller for the slow mult/div unit: latches the request, drives the
// unit handshake, stalls ID while busy and drains the unit safely on flush.
module ibex_multdiv_issue
  import ibex_pkg::*;
#(
  parameter  int unsigned MaxCycles = MD_MAX_CYCLES,
  localparam int unsigned CntW      = $clog2(MaxCycles + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                req_valid_i,
  input  logic                req_is_div_i,
  input  md_op_e              req_operator_i,
  input  logic [1:0]          req_signed_mode_i,
  input  logic [MD_OP_W-1:0]  req_op_a_i,
  input  logic [MD_OP_W-1:0]  req_op_b_i,
  output logic                req_ready_o,

  input  logic                flush_i,
  input  logic                wb_ready_i,
  output logic                result_valid_o,
  output logic [MD_OP_W-1:0]  result_o,
  output logic                stall_o,
  output logic                timeout_o,

  output logic                mult_en_o,
  output logic                div_en_o,
  output logic                mult_sel_o,
  output logic                div_sel_o,
  output md_op_e              operator_o,
  output logic [1:0]          signed_mode_o,
  output logic [MD_OP_W-1:0]  op_a_o,
  output logic [MD_OP_W-1:0]  op_b_o,
  output logic                multdiv_ready_id_o,

  input  logic                multdiv_valid_i,
  input  logic [MD_OP_W-1:0]  multdiv_result_i,

  input  logic [MD_IMD_W-1:0] imd_val_d_i  [2],
  input  logic [1:0]          imd_val_we_i,
  output logic [MD_IMD_W-1:0] imd_val_q_o  [2]
);

  md_issue_fsm_e   r_state;
  md_issue_fsm_e   w_state_d;
  md_req_t         r_req;
  logic [CntW-1:0] r_cnt;
  logic            r_timeout;
  logic            w_accept;
  logic            w_active;

  assign w_accept = (r_state == MD_ISS_IDLE) & req_valid_i & ~flush_i;
  assign w_active = (r_state != MD_ISS_IDLE);

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      MD_ISS_IDLE: begin
        if (w_accept) w_state_d = MD_ISS_BUSY;
      end
      MD_ISS_BUSY: begin
        if (flush_i) begin
          w_state_d = MD_ISS_DRAIN;
        end else if (multdiv_valid_i && wb_ready_i) begin
          w_state_d = MD_ISS_IDLE;
        end
      end
      MD_ISS_DRAIN: begin
        if (multdiv_valid_i) w_state_d = MD_ISS_IDLE;
      end
      default: w_state_d = MD_ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= MD_ISS_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Request capture; held until the next accepted instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.operator    <= req_operator_i;
      r_req.signed_mode <= req_signed_mode_i;
      r_req.is_div      <= req_is_div_i;
      r_req.op_a        <= req_op_a_i;
      r_req.op_b        <= req_op_b_i;
    end
  end

  // Busy-cycle counter saturates at the bound; the timeout flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (w_active && (r_cnt != CntW'(MaxCycles))) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_active && (r_cnt == CntW'(MaxCycles - 1))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Unit handshake and writeback outputs; a flush in BUSY suppresses that cycle's transfer.
  always_comb begin
    req_ready_o        = 1'b0;
    result_valid_o     = 1'b0;
    result_o           = '0;
    mult_en_o          = 1'b0;
    div_en_o           = 1'b0;
    mult_sel_o         = 1'b0;
    div_sel_o          = 1'b0;
    multdiv_ready_id_o = 1'b0;
    unique case (r_state)
      MD_ISS_IDLE: begin
        req_ready_o = 1'b1;
      end
      MD_ISS_BUSY: begin
        mult_en_o          = ~r_req.is_div;
        mult_sel_o         = ~r_req.is_div;
        div_en_o           = r_req.is_div;
        div_sel_o          = r_req.is_div;
        result_valid_o     = multdiv_valid_i & ~flush_i;
        result_o           = multdiv_result_i;
        multdiv_ready_id_o = wb_ready_i & ~flush_i;
      end
      MD_ISS_DRAIN: begin
        mult_en_o          = ~r_req.is_div;
        mult_sel_o         = ~r_req.is_div;
        div_en_o           = r_req.is_div;
        div_sel_o          = r_req.is_div;
        multdiv_ready_id_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_o       = w_active | w_accept;
  assign timeout_o     = r_timeout;
  assign operator_o    = r_req.operator;
  assign signed_mode_o = r_req.signed_mode;
  assign op_a_o        = r_req.op_a;
  assign op_b_o        = r_req.op_b;

  ibex_multdiv_imd_regs u_imd_regs (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imd_val_d_i  (imd_val_d_i),
    .imd_val_we_i (imd_val_we_i),
    .imd_val_q_o  (imd_val_q_o)
  );

endmodule
